// File: rtl/demux_1x32_capture.sv
// Purpose : steers a serial bit into one of K slots chosen by sel and assembles a K-bit word.
// Latency : out_valid rises 1 cycle after the accept that fills the last empty slot.
// Backpres: in_ready drops while a full word waits; the word is held until out_ready.
//
// Ports:
//   clk, rst         - clock and synchronous active-high reset
//   clear            - synchronous abort, discards the partial or held word
//   in_valid/in_ready, d, sel - upstream bit and its destination slot
//   out_word/out_valid/out_ready - assembled word and its handshake
//   fill_mask, fill_count - slots written since the last flush and their number
//   dup_err          - one-cycle pulse after an accept that rewrote a filled slot
module demux_1x32_capture #(
    parameter int K = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   d,
    input  logic [$clog2(K)-1:0]   sel,
    output logic [K-1:0]           out_word,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [K-1:0]           fill_mask,
    output logic [$clog2(K):0]     fill_count,
    output logic                   dup_err
);

    localparam int CW = $clog2(K) + 1;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [K-1:0]    r_word;
    logic [K-1:0]    w_word_nxt;
    logic [K-1:0]    r_mask;
    logic [K-1:0]    w_mask_nxt;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic            r_dup;
    logic            w_dup_nxt;
    logic            w_accept;
    logic            w_hit;

    assign w_accept = in_valid && (r_state == COLLECT);
    assign w_hit    = r_mask[sel];

    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_mask_nxt  = r_mask;
        w_count_nxt = r_count;
        w_dup_nxt   = 1'b0;

        if (clear) begin
            // Abort wins over any accept or handshake in the same cycle.
            w_state_nxt = COLLECT;
            w_word_nxt  = '0;
            w_mask_nxt  = '0;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        w_word_nxt[sel] = d;
                        w_mask_nxt[sel] = 1'b1;
                        if (w_hit) begin
                            // Rewrite of a filled slot: data updates, count does not.
                            w_dup_nxt = 1'b1;
                        end else begin
                            w_count_nxt = r_count + CW'(1);
                            // Enter HOLD on the same edge the last slot fills.
                            if (r_count == CW'(K - 1)) begin
                                w_state_nxt = HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        w_state_nxt = COLLECT;
                        w_word_nxt  = '0;
                        w_mask_nxt  = '0;
                        w_count_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = COLLECT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COLLECT;
            r_word  <= '0;
            r_mask  <= '0;
            r_count <= '0;
            r_dup   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
            r_mask  <= w_mask_nxt;
            r_count <= w_count_nxt;
            r_dup   <= w_dup_nxt;
        end
    end

    // Every output comes straight from a register or the state bit.
    assign in_ready   = (r_state == COLLECT);
    assign out_valid  = (r_state == HOLD);
    assign out_word   = r_word;
    assign fill_mask  = r_mask;
    assign fill_count = r_count;
    assign dup_err    = r_dup;

endmodule

// File: tb/tb_demux_1x32_capture.sv
// Purpose : random and directed stimulus for demux_1x32_capture against a slot-array model.
// Latency : model status is compared every cycle; finished words go through a queue.
// Backpres: the word monitor pops only on an out_valid/out_ready handshake.
module tb_demux_1x32_capture;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic        d;
    logic [4:0]  sel;
    logic [31:0] out_word;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] fill_mask;
    logic [5:0]  fill_count;
    logic        dup_err;

    int checks = 0;
    int errors = 0;

    // Reference model: one entry per slot.
    bit m_set[32];
    bit m_val[32];
    bit m_hold;
    bit m_dup;
    logic [31:0] exp_q[$];

    demux_1x32_capture #(.K(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .d          (d),
        .sel        (sel),
        .out_word   (out_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill_mask  (fill_mask),
        .fill_count (fill_count),
        .dup_err    (dup_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_val();
        logic [31:0] w;
        for (int i = 0; i < 32; i++) w[i] = m_val[i];
        return w;
    endfunction

    function automatic logic [31:0] pack_set();
        logic [31:0] w;
        for (int i = 0; i < 32; i++) w[i] = m_set[i];
        return w;
    endfunction

    function automatic int filled();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_set[i]);
        return n;
    endfunction

    task automatic model_flush();
        for (int i = 0; i < 32; i++) begin
            m_set[i] = 1'b0;
            m_val[i] = 1'b0;
        end
        m_hold = 1'b0;
        m_dup  = 1'b0;
    endtask

    // Applies the design rules to the inputs that were present at the edge.
    task automatic model_step(input bit v, input bit dd, input logic [4:0] s,
                              input bit cl, input bit ordy, input bit r);
        if (r || cl) begin
            // A held word that is reset or cleared is never delivered.
            if (m_hold && exp_q.size() > 0) void'(exp_q.pop_back());
            model_flush();
        end else if (m_hold) begin
            m_dup = 1'b0;
            if (ordy) model_flush();
        end else begin
            m_dup = 1'b0;
            if (v) begin
                m_dup    = m_set[s];
                m_val[s] = dd;
                m_set[s] = 1'b1;
                if (filled() == 32) begin
                    m_hold = 1'b1;
                    exp_q.push_back(pack_val());
                end
            end
        end
    endtask

    task automatic check_status();
        chk("in_ready",   {31'd0, in_ready},   {31'd0, !m_hold});
        chk("out_valid",  {31'd0, out_valid},  {31'd0, m_hold});
        chk("out_word",   out_word,            pack_val());
        chk("fill_mask",  fill_mask,           pack_set());
        chk("fill_count", {26'd0, fill_count}, 32'(filled()));
        chk("dup_err",    {31'd0, dup_err},    {31'd0, m_dup});
    endtask

    task automatic cycle(input bit v, input bit dd, input logic [4:0] s,
                         input bit cl, input bit ordy, input bit r);
        in_valid  = v;
        d         = dd;
        sel       = s;
        clear     = cl;
        out_ready = ordy;
        rst       = r;
        @(posedge clk);
        model_step(v, dd, s, cl, ordy, r);
        @(negedge clk);
        check_status();
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 1'($urandom), 5'($urandom), 1'b0, ordy, 1'b0);
    endtask

    // Writes every slot of w once; optionally shuffled and with idle gaps.
    task automatic fill_word(input logic [31:0] w, input bit shuffle, input bit gaps);
        int p[32];
        int j;
        int t;
        logic [4:0] s;
        for (int i = 0; i < 32; i++) p[i] = i;
        if (shuffle) begin
            for (int i = 31; i > 0; i--) begin
                j    = int'($urandom_range(i, 0));
                t    = p[i];
                p[i] = p[j];
                p[j] = t;
            end
        end
        for (int i = 0; i < 32; i++) begin
            if (gaps) idle(1'b0);
            s = p[i][4:0];
            cycle(1'b1, w[s], s, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Word scoreboard: sampled between edges, after the driver has settled inputs.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (out_valid && out_ready && !rst && !clear) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word_handshake actual=%h required=none_pending", out_word);
                end else begin
                    chk("word_handshake", out_word, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        d         = 1'b0;
        sel       = 5'd0;
        out_ready = 1'b0;
        model_flush();

        cycle(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("reset_fill_count", {26'd0, fill_count}, 32'd0);

        // In-order fill, d = sel[0].
        for (int i = 0; i < 32; i++) begin
            logic [4:0] s;
            s = 5'(i);
            cycle(1'b1, s[0], s, 1'b0, 1'b0, 1'b0);
        end
        chk("inorder_word", out_word, 32'hAAAAAAAA);
        chk("inorder_valid", {31'd0, out_valid}, 32'd1);
        idle(1'b1);

        // Shuffled fill with backpressure; in_valid noise while held.
        fill_word(32'hDEADBEEF, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'($urandom), 1'($urandom), 5'($urandom), 1'b0, 1'b0, 1'b0);
            chk("held_word", out_word, 32'hDEADBEEF);
        end
        idle(1'b1);
        chk("post_hs_count", {26'd0, fill_count}, 32'd0);
        chk("post_hs_ready", {31'd0, in_ready}, 32'd1);

        // Duplicate write to slot 7.
        cycle(1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0);
        chk("dup_pulse", {31'd0, dup_err}, 32'd1);
        chk("dup_count", {26'd0, fill_count}, 32'd1);
        chk("dup_bit7", {31'd0, out_word[7]}, 32'd0);
        idle(1'b0);
        chk("dup_one_cycle", {31'd0, dup_err}, 32'd0);
        cycle(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);

        // Clear mid-fill with a simultaneous accept (slot 3 is already filled).
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'($urandom), 5'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        chk("clear_mask", fill_mask, 32'd0);
        chk("clear_dup", {31'd0, dup_err}, 32'd0);

        // Reset while holding, then a normal fill and handshake.
        w = $urandom;
        fill_word(w, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("rst_hold_valid", {31'd0, out_valid}, 32'd0);
        fill_word(~w, 1'b1, 1'b0);
        idle(1'b1);

        // in_valid toggling every cycle.
        fill_word($urandom, 1'b1, 1'b1);
        idle(1'b1);

        // Random soak including rare clears and resets.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom % 4) != 0, 1'($urandom), 5'($urandom),
                  ($urandom % 80) == 0, ($urandom % 3) == 0, ($urandom % 300) == 0);
        end
        cycle(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
